// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB master slice.
//   data_t / addr_t / strb_t  - bus field types
//   apb_fsm_enum              - transfer state machine encoding
//   apb_mst_cmd_t             - command captured on acceptance
//   apb_mst_rsp_t             - registered completion response
// Widths come from the `APB_ADDR_WIDTH / `APB_STRB_WIDTH macros (default 32 / 4).
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif

package apb_pkg;

    localparam int unsigned APB_DATA_WIDTH = 8 * `APB_STRB_WIDTH;

    typedef logic [APB_DATA_WIDTH-1:0]  data_t;
    typedef logic [`APB_ADDR_WIDTH-1:0] addr_t;
    typedef logic [`APB_STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_fsm_enum;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
        strb_t strb;
    } apb_mst_cmd_t;

    typedef struct packed {
        data_t rdata;
        logic  err;
        logic  timeout;
    } apb_mst_rsp_t;

endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus signal bundle.
//   mst_mp - master view: drives PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB;
//            samples PREADY, PRDATA, PSLVERR.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif

interface apb_if;
    import apb_pkg::*;

    logic  PSEL;
    logic  PENABLE;
    logic  PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    strb_t PSTRB;
    logic  PREADY;
    data_t PRDATA;
    logic  PSLVERR;

    modport mst_mp (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mst_timeout.sv
// apb_mst_timeout: ACCESS-phase watchdog for apb_master.
//   PCLK, PRESETn - clock, asynchronous active-low reset
//   clear         - restart the count (held while not waiting in ACCESS)
//   count_en      - one more ACCESS cycle with PREADY low
//   expired       - this waiting cycle is number TIMEOUT_CYCLES
module apb_mst_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // count holds the waits already seen, so the current cycle is count+1.
    assign expired = count_en && (count == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: command/response front end driving an APB bus as master.
//   PCLK, PRESETn       - clock (rising edge), asynchronous active-low reset
//   apb                 - apb_if.mst_mp bus port
//   cmd_valid/cmd_ready - command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_strb
//   rsp_valid           - one-cycle completion pulse; rsp_rdata, rsp_err, rsp_timeout hold
// Optional: define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif

module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    apb_if.mst_mp                      apb,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [`APB_ADDR_WIDTH-1:0] cmd_addr,
    input  data_t                      cmd_wdata,
    input  logic [`APB_STRB_WIDTH-1:0] cmd_strb,
    output logic                       rsp_valid,
    output data_t                      rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be 1..255");
    end

    apb_fsm_enum  state, state_d;
    apb_mst_cmd_t cmd_q;
    apb_mst_rsp_t rsp_q;
    logic         rsp_valid_q;
    logic         accept;
    logic         done;
    logic         timed_out;
    logic         expired;

`ifdef APB_MST_TIMEOUT_EN
    apb_mst_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state != ACCESS),
        .count_en((state == ACCESS) && !apb.PREADY),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // PREADY/PRDATA/PSLVERR are only looked at inside the ACCESS branch.
    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    cmd_ready = 1'b1;
                    done      = 1'b1;
                    state_d   = cmd_valid ? SETUP : IDLE;
                end else if (expired) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Read commands are captured with zero data/strobes so the bus never shows them.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cmd_q <= '0;
        end else if (accept) begin
            cmd_q.write <= cmd_write;
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_write ? cmd_wdata : '0;
            cmd_q.strb  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= done || timed_out;
            if (done) begin
                rsp_q.rdata   <= cmd_q.write ? '0 : apb.PRDATA;
                rsp_q.err     <= apb.PSLVERR;
                rsp_q.timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_q.rdata   <= '0;
                rsp_q.err     <= 1'b1;
                rsp_q.timeout <= 1'b1;
            end
        end
    end

    assign apb.PSEL    = (state != IDLE);
    assign apb.PENABLE = (state == ACCESS);
    assign apb.PWRITE  = cmd_q.write;
    assign apb.PADDR   = cmd_q.addr;
    assign apb.PWDATA  = cmd_q.wdata;
    assign apb.PSTRB   = cmd_q.strb;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;
`ifdef APB_MST_TIMEOUT_EN
    assign rsp_timeout = rsp_q.timeout;
`else
    assign rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
    import apb_pkg::*;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned TB_TO = 8;
`else
    localparam int unsigned TB_TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    data_t       cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    data_t       rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    always #5 clk = ~clk;

    apb_if bus();

    apb_master #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .PCLK       (clk),
        .PRESETn    (rst_n),
        .apb        (bus),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    // ---------------- slave model: 64 words, writes below 0x010 rejected ----------
    data_t       mem [0:63];
    logic        mem_ready = 1'b0;
    int unsigned wait_n = 0;
    logic        stuck = 1'b0;
    int unsigned acc_cnt = 0;
    logic        access;
    logic [5:0]  widx;
    logic        ro;

    assign access      = bus.PSEL && bus.PENABLE;
    assign widx        = bus.PADDR[7:2];
    assign ro          = bus.PADDR < 32'h10;
    assign bus.PREADY  = access && !stuck && (acc_cnt >= wait_n);
    assign bus.PRDATA  = mem[widx];
    assign bus.PSLVERR = access && bus.PREADY && bus.PWRITE && ro;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[1]    <= 32'h1111_2222;
            mem_ready <= 1'b1;
        end else if (access && bus.PREADY && bus.PWRITE && !ro) begin
            for (int b = 0; b < 4; b++)
                if (bus.PSTRB[b]) mem[widx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
        end
        if (access && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else                       acc_cnt <= 0;
    end

    // ---------------- scoreboard and bus monitor ----------------
    typedef struct {
        data_t rdata;
        logic  err;
        logic  timeout;
    } exp_t;

    exp_t        sb[$];
    int unsigned pcyc = 0;
    int unsigned acc_pcyc = 0;
    int unsigned rsp_times[$];
    int          errors = 0;
    int          checks = 0;
    int          psel_cnt = 0, pen_cnt = 0, rd_bad = 0, stab_bad = 0, rsp_cnt = 0;
    logic [68:0] prev_bus = '0;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (bus.PSEL) psel_cnt++;
        if (bus.PENABLE) pen_cnt++;
        if (bus.PSEL && !bus.PWRITE && (bus.PSTRB != 0 || bus.PWDATA != 0)) rd_bad++;
        if (bus.PENABLE && {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB} != prev_bus) stab_bad++;
        prev_bus = {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB};
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_times.push_back(pcyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (rdata=%h)", rsp_rdata);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, e.rdata);
                end
                checks++;
                if (rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %b expected %b", rsp_err, e.err);
                end
                checks++;
                if (rsp_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL rsp_timeout: got %b expected %b", rsp_timeout, e.timeout);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        @(negedge clk);
        #1;
        psel_cnt = 0; pen_cnt = 0; rd_bad = 0; stab_bad = 0; rsp_cnt = 0;
        rsp_times.delete();
    endtask

    task automatic send(input logic w, input logic [31:0] a, input data_t d, input logic [3:0] s,
                        input logic expect_rsp, input data_t er, input logic ee, input logic et);
        int unsigned n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            errors++; checks++;
            $display("FAIL accept_wait: got cmd_ready=0 for %0d cycles expected 1", n);
        end else begin
            e.rdata = er; e.err = ee; e.timeout = et;
            if (expect_rsp) sb.push_back(e);
            acc_pcyc = pcyc;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending responses expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk("rst_psel", 64'(bus.PSEL), 64'd0);
        chk("rst_penable", 64'(bus.PENABLE), 64'd0);
        chk("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        chk("rst_paddr", 64'(bus.PADDR), 64'd0);
        chk("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        chk("rst_pstrb", 64'(bus.PSTRB), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic test_write_wait();
        clear_stats();
        wait_n = 3;
        send(1'b1, 32'h020, 32'hDEAD_BEEF, 4'hF, 1'b1, '0, 1'b0, 1'b0);
        idle_cmd();
        drain("write_wait");
        chk("ww_psel_cycles", 64'(psel_cnt), 64'd5);
        chk("ww_penable_cycles", 64'(pen_cnt), 64'd4);
        chk("ww_rsp_pulses", 64'(rsp_cnt), 64'd1);
        chk("ww_stable", 64'(stab_bad), 64'd0);
    endtask

    task automatic test_read();
        clear_stats();
        wait_n = 1;
        send(1'b0, 32'h020, 32'h1234_5678, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_cmd();
        drain("read");
        chk("rd_psel_cycles", 64'(psel_cnt), 64'd3);
        chk("rd_penable_cycles", 64'(pen_cnt), 64'd2);
        chk("rd_strb_data_zero", 64'(rd_bad), 64'd0);
        chk("rd_latency", 64'(rsp_times[0] - acc_pcyc), 64'd4);
    endtask

    task automatic test_slverr();
        clear_stats();
        wait_n = 0;
        send(1'b1, 32'h005, 32'hCAFE_F00D, 4'hF, 1'b1, '0, 1'b1, 1'b0);
        idle_cmd();
        drain("slverr");
        chk("se_penable_cycles", 64'(pen_cnt), 64'd1);
        chk("se_latency", 64'(rsp_times[0] - acc_pcyc), 64'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("se_hold", 64'({rsp_valid, rsp_err}), 64'b01);
        send(1'b0, 32'h005, '0, 4'h0, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
        idle_cmd();
        drain("slverr_readback");
    endtask

    task automatic test_strobe();
        wait_n = 0;
        send(1'b1, 32'h040, 32'hAABB_CCDD, 4'b0101, 1'b1, '0, 1'b0, 1'b0);
        send(1'b0, 32'h040, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h00BB_00DD, 1'b0, 1'b0);
        idle_cmd();
        drain("strobe");
    endtask

    task automatic test_back_to_back();
        clear_stats();
        wait_n = 0;
        for (int i = 0; i < 3; i++)
            send(1'b1, 32'h030 + 32'(4 * i), 32'h100 + 32'(i), 4'hF, 1'b1, '0, 1'b0, 1'b0);
        idle_cmd();
        drain("b2b");
        chk("b2b_rsp_pulses", 64'(rsp_cnt), 64'd3);
        chk("b2b_psel_cycles", 64'(psel_cnt), 64'd6);
        if (rsp_times.size() == 3) begin
            chk("b2b_gap0", 64'(rsp_times[1] - rsp_times[0]), 64'd2);
            chk("b2b_gap1", 64'(rsp_times[2] - rsp_times[1]), 64'd2);
        end
        send(1'b0, 32'h034, '0, 4'h0, 1'b1, 32'h101, 1'b0, 1'b0);
        idle_cmd();
        drain("b2b_readback");
    endtask

`ifdef APB_MST_TIMEOUT_EN
    task automatic test_timeout();
        clear_stats();
        stuck = 1'b1;
        send(1'b0, 32'h020, '0, 4'h0, 1'b1, '0, 1'b1, 1'b1);
        idle_cmd();
        drain("timeout");
        chk("to_penable_cycles", 64'(pen_cnt), 64'd8);
        chk("to_psel_cycles", 64'(psel_cnt), 64'd9);
        stuck = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int unsigned n = 0;
        clear_stats();
        wait_n = 20;
        send(1'b1, 32'h044, 32'h5555_5555, 4'hF, 1'b0, '0, 1'b0, 1'b0);
        idle_cmd();
        while (!bus.PENABLE && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rm_in_access", 64'(bus.PENABLE), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_bus_zero", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}), 64'd0);
        chk("rm_addr_data_zero", {bus.PADDR, bus.PWDATA}, 64'd0);
        chk("rm_rsp_zero", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rm_cmd_ready", 64'(cmd_ready), 64'd1);
        wait_n = 0;
        send(1'b0, 32'h044, '0, 4'h0, 1'b1, '0, 1'b0, 1'b0);
        idle_cmd();
        drain("reset_mid");
        chk("rm_rsp_pulses", 64'(rsp_cnt), 64'd1);
        if (rsp_times.size() == 1) chk("rm_first_latency", 64'(rsp_times[0] - acc_pcyc), 64'd3);
    endtask

    initial begin
        test_reset();
        test_write_wait();
        test_read();
        test_slverr();
        test_strobe();
        test_back_to_back();
`ifdef APB_MST_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS wait cycles before abort (legal 1..255; used only when APB_MST_TIMEOUT_EN is defined).
REQ-002 SHALL have port apb_master.PCLK  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port apb_master.PRESETn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port apb_master  modport apb_if.mst_mp  -  drives PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB; samples PREADY, PRDATA, PSLVERR.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at a clock edge.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  `APB_ADDR_WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  input  data_t  write data.
REQ-010 SHALL have port cmd_strb  input  `APB_STRB_WIDTH  byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-012 SHALL have port rsp_rdata  output  data_t  read data (0 for writes).
REQ-013 SHALL have port rsp_err  output  1  PSLVERR or timeout.
REQ-014 SHALL have port rsp_timeout  output  1  transfer aborted by watchdog.

Function
REQ-015 SHALL use FSM IDLE, SETUP, ACCESS (apb_fsm_enum), registered state.
REQ-016 SHALL assert cmd_ready combinationally only in IDLE, or in ACCESS when PREADY=1.
REQ-017 SHALL capture cmd_* into registers on acceptance and move to SETUP next cycle.
REQ-018 SHALL in SETUP drive PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB from captured command, then go to ACCESS unconditionally.
REQ-019 SHALL in ACCESS drive PSEL=1, PENABLE=1, all address/control/data stable until PREADY=1.
REQ-020 SHALL on ACCESS with PREADY=1 go to SETUP if a command was accepted that cycle, else IDLE (PSEL=0, PENABLE=0).
REQ-021 SHALL force PSTRB=0 and PWDATA=0 on reads.
REQ-022 SHALL pulse rsp_valid the cycle after completion, with rsp_rdata=registered PRDATA (reads), rsp_err=registered PSLVERR.
REQ-023 SHALL keep rsp_rdata/rsp_err/rsp_timeout holding last response between pulses.
REQ-024 SHALL give minimum latency acceptance-to-rsp_valid of 3 cycles (zero-wait slave); back-to-back transfers SHALL occupy 2 cycles each.
REQ-025 SHALL ignore PREADY, PSLVERR, PRDATA outside ACCESS.

Reset
REQ-026 SHALL on PRESETn low immediately set state IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA, PSTRB=0; rsp_valid, rsp_err, rsp_timeout=0; rsp_rdata=0; captured command cleared.
REQ-027 SHALL on reset mid-transfer drop the transfer with no response; first accept possible in the first cycle after release.

Configuration
REQ-028 SHALL with APB_MST_TIMEOUT_EN defined count consecutive ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYCLES go to IDLE, deassert PSEL/PENABLE, pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-029 SHALL with APB_MST_TIMEOUT_EN undefined wait indefinitely, tie rsp_timeout to 0, instantiate no counter logic.

Structure
REQ-030 SHALL place apb_mst_cmd_t and apb_mst_rsp_t structs, and strb_t if absent, in apb_pkg; reuse apb_fsm_enum, data_t.
REQ-031 SHALL implement the watchdog as sub-module apb_mst_timeout (clear, count enable, expired flag), instantiated only under APB_MST_TIMEOUT_EN.

Verification
REQ-032 Write 0x020, data 0xDEADBEEF, strb 0xF, slave 4-wait ACCESS -> PSEL high 5 cycles, PENABLE 4, rsp_valid once, rsp_err=0.
REQ-033 Read 0x020 after REQ-032, slave 2 ACCESS cycles -> rsp_rdata=0xDEADBEEF, PSTRB=0 throughout, rsp_err=0.
REQ-034 Write 0x005 to read-only slave region -> PSLVERR in first ACCESS cycle, rsp_err=1, memory unchanged on readback.
REQ-035 cmd_valid held for 3 writes, zero-wait slave -> SETUP/ACCESS alternate with no IDLE gap, 3 rsp_valid pulses 2 cycles apart.
REQ-036 APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1; PRESETn pulsed mid-ACCESS -> all outputs 0 same cycle, no rsp_valid.
